// File: rtl/tag_array_flush_sram.sv
// 1R1W lane-masked tag array with registered reads and a row-by-row
// zeroing engine that runs after reset and on flush_req.
module tag_array_flush_sram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 184,
    parameter int MASK_BITS = 8,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    R0_addr,
    input  logic                 R0_en,
    output logic [WIDTH-1:0]     R0_data,
    output logic                 R0_valid,
    input  logic [ADDR_W-1:0]    W0_addr,
    input  logic                 W0_en,
    input  logic [WIDTH-1:0]     W0_data,
    input  logic [MASK_BITS-1:0] W0_mask,
    input  logic                 flush_req,
    output logic                 busy
);

    localparam int L = WIDTH / MASK_BITS;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    if (WIDTH % MASK_BITS != 0) begin : g_bad_mask
        $error("WIDTH must be a multiple of MASK_BITS");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [0:0]        state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;
    logic              idle;
    logic              w_ok;
    logic              r_in;
    logic [WIDTH-1:0]  lane_we;
    logic [WIDTH-1:0]  rd_row;

    assign idle = (state == IDLE);
    assign w_ok = idle && W0_en && ({1'b0, W0_addr} < DEPTH_W);
    assign r_in = ({1'b0, R0_addr} < DEPTH_W);

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < MASK_BITS; k++) begin
            lane_we[k*L +: L] = {L{W0_mask[k]}};
        end
    end

    // Out-of-range reads return zero; bypass only merges in-range writes.
    always_comb begin
        rd_row = '0;
        if (r_in) begin
            rd_row = mem[R0_addr];
            if (BYPASS != 0 && w_ok && W0_addr == R0_addr) begin
                rd_row = (rd_row & ~lane_we) | (W0_data & lane_we);
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == FLUSH) begin
            ptr_nx = ptr + ADDR_W'(1);
            if (ptr == LAST) begin
                state_nx = IDLE;
                ptr_nx   = '0;
            end
        end else if (flush_req) begin
            state_nx = FLUSH;
            ptr_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FLUSH;
            ptr      <= '0;
            busy     <= 1'b1;
            R0_valid <= 1'b0;
            R0_data  <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            busy     <= (state_nx == FLUSH);
            R0_valid <= idle && R0_en;
            if (idle && R0_en) begin
                R0_data <= rd_row;
            end
        end
    end

    // Storage has no reset; the flush engine is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == FLUSH) begin
                mem[ptr] <= '0;
            end else if (w_ok) begin
                mem[W0_addr] <= (mem[W0_addr] & ~lane_we) | (W0_data & lane_we);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && busy) begin
            assert (!(R0_en || W0_en))
            else $warning("access dropped while flush engine is busy");
        end
    end

endmodule

// File: tb/tb_tag_array_flush_sram.sv
// Bench for tag_array_flush_sram: two 64x184 copies (bypass on/off)
// driven in lockstep, plus a 48x32 copy for out-of-range handling.
module tb_tag_array_flush_sram;

    localparam int D = 64;
    localparam int W = 184;
    localparam int M = 8;
    localparam int AW = 6;
    localparam int CW = 32;
    localparam int CM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AW-1:0] r_addr, w_addr;
    logic          r_en, w_en, flush_req;
    logic [W-1:0]  w_data;
    logic [M-1:0]  w_mask;
    logic [W-1:0]  a_data, b_data;
    logic          a_valid, b_valid, a_busy, b_busy;

    logic [AW-1:0] c_r_addr, c_w_addr;
    logic          c_r_en, c_w_en, c_flush;
    logic [CW-1:0] c_w_data, c_data;
    logic [CM-1:0] c_w_mask;
    logic          c_valid, c_busy;

    always #5 clk = ~clk;

    tag_array_flush_sram #(.DEPTH(D), .WIDTH(W), .MASK_BITS(M), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(a_data), .R0_valid(a_valid),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask),
        .flush_req(flush_req), .busy(a_busy)
    );

    tag_array_flush_sram #(.DEPTH(D), .WIDTH(W), .MASK_BITS(M), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(r_addr), .R0_en(r_en), .R0_data(b_data), .R0_valid(b_valid),
        .W0_addr(w_addr), .W0_en(w_en), .W0_data(w_data), .W0_mask(w_mask),
        .flush_req(flush_req), .busy(b_busy)
    );

    tag_array_flush_sram #(.DEPTH(48), .WIDTH(CW), .MASK_BITS(CM), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .R0_addr(c_r_addr), .R0_en(c_r_en), .R0_data(c_data), .R0_valid(c_valid),
        .W0_addr(c_w_addr), .W0_en(c_w_en), .W0_data(c_w_data), .W0_mask(c_w_mask),
        .flush_req(c_flush), .busy(c_busy)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] da;
        logic [W-1:0] db;
        logic         bz;
    } exp_t;

    typedef struct {
        logic          v;
        logic [CW-1:0] d;
    } cexp_t;

    typedef struct {
        logic          re;
        logic [AW-1:0] ra;
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic [M-1:0]  wm;
        logic          ev;
        logic [W-1:0]  eda;
        logic [W-1:0]  edb;
    } vec_t;

    exp_t  q[$];
    cexp_t cq[$];
    vec_t  tbl[12];

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0]  held_a, held_b;
    logic [CW-1:0] held_c;
    logic [W-1:0]  ones, lane0, lane01, top;

    task automatic chk1(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic chkc(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic step(
        input logic re, input logic [AW-1:0] ra,
        input logic we, input logic [AW-1:0] wa,
        input logic [W-1:0] wd, input logic [M-1:0] wm,
        input logic fr, input logic ev,
        input logic [W-1:0] eda, input logic [W-1:0] edb,
        input logic eb
    );
        exp_t e;
        r_en = re; r_addr = ra;
        w_en = we; w_addr = wa; w_data = wd; w_mask = wm;
        flush_req = fr;
        e.v  = ev;
        e.bz = eb;
        if (!rst_n) begin
            e.da = '0; e.db = '0;
        end else if (ev) begin
            e.da = eda; e.db = edb;
        end else begin
            e.da = held_a; e.db = held_b;
        end
        held_a = e.da;
        held_b = e.db;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk1("valid_byp", a_valid, e.v);
        chk1("valid_nobyp", b_valid, e.v);
        chk1("busy_byp", a_busy, e.bz);
        chk1("busy_nobyp", b_busy, e.bz);
        chkw("data_byp", a_data, e.da);
        chkw("data_nobyp", b_data, e.db);
    endtask

    task automatic nop(input logic eb);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, eb);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] ea, input logic [W-1:0] eb_);
        step(1'b1, a, 1'b0, '0, '0, '0, 1'b0, 1'b1, ea, eb_, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [M-1:0] m);
        step(1'b0, '0, 1'b1, a, d, m, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic stepc(
        input logic re, input logic [AW-1:0] ra,
        input logic we, input logic [AW-1:0] wa,
        input logic [CW-1:0] wd, input logic [CM-1:0] wm,
        input logic ev, input logic [CW-1:0] ed
    );
        cexp_t e;
        c_r_en = re; c_r_addr = ra;
        c_w_en = we; c_w_addr = wa; c_w_data = wd; c_w_mask = wm;
        e.v = ev;
        e.d = ev ? ed : held_c;
        held_c = e.d;
        cq.push_back(e);
        @(posedge clk);
        #1;
        e = cq.pop_front();
        chk1("c_valid", c_valid, e.v);
        chk1("c_busy", c_busy, 1'b0);
        chkc("c_data", c_data, e.d);
    endtask

    function automatic logic [W-1:0] pat(input int i);
        return {8{23'(i * 37 + 5)}};
    endfunction

    function automatic logic [CW-1:0] cpat(input int i);
        return 32'hA5C3_0000 | CW'(i);
    endfunction

    function automatic vec_t mk(
        input logic re, input logic [AW-1:0] ra,
        input logic we, input logic [AW-1:0] wa,
        input logic [W-1:0] wd, input logic [M-1:0] wm,
        input logic ev, input logic [W-1:0] eda, input logic [W-1:0] edb
    );
        vec_t t;
        t.re = re; t.ra = ra; t.we = we; t.wa = wa;
        t.wd = wd; t.wm = wm; t.ev = ev; t.eda = eda; t.edb = edb;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        held_a = '0; held_b = '0; held_c = '0;
        ones   = '1;
        lane0  = ones >> 161;
        lane01 = ones >> 138;
        top    = ones << 161;
        r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_addr = '0;
        w_data = '0; w_mask = '0; flush_req = 1'b0;
        c_r_en = 1'b0; c_r_addr = '0; c_w_en = 1'b0; c_w_addr = '0;
        c_w_data = '0; c_w_mask = '0; c_flush = 1'b0;

        tbl[0]  = mk(1'b0, 6'd0,  1'b1, 6'd5,  ones, 8'h01, 1'b0, '0, '0);
        tbl[1]  = mk(1'b0, 6'd0,  1'b1, 6'd5,  '0,   8'hFE, 1'b0, '0, '0);
        tbl[2]  = mk(1'b1, 6'd5,  1'b0, 6'd0,  '0,   8'h00, 1'b1, lane0, lane0);
        tbl[3]  = mk(1'b1, 6'd9,  1'b1, 6'd9,  ones, 8'h80, 1'b1, top, '0);
        tbl[4]  = mk(1'b1, 6'd9,  1'b0, 6'd0,  '0,   8'h00, 1'b1, top, top);
        tbl[5]  = mk(1'b1, 6'd5,  1'b1, 6'd9,  '0,   8'h00, 1'b1, lane0, lane0);
        tbl[6]  = mk(1'b1, 6'd9,  1'b0, 6'd0,  '0,   8'h00, 1'b1, top, top);
        tbl[7]  = mk(1'b1, 6'd13, 1'b1, 6'd12, ones, 8'hFF, 1'b1, '0, '0);
        tbl[8]  = mk(1'b1, 6'd12, 1'b0, 6'd0,  '0,   8'h00, 1'b1, ones, ones);
        tbl[9]  = mk(1'b1, 6'd5,  1'b1, 6'd5,  ones, 8'h02, 1'b1, lane01, lane0);
        tbl[10] = mk(1'b1, 6'd5,  1'b0, 6'd0,  '0,   8'h00, 1'b1, lane01, lane01);
        tbl[11] = mk(1'b0, 6'd0,  1'b0, 6'd0,  '0,   8'h00, 1'b0, '0, '0);

        // Reset for three cycles, then the power-on flush.
        repeat (3) nop(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) nop(i < D - 1);
        rd(6'd0, '0, '0);
        rd(6'd31, '0, '0);
        rd(6'd63, '0, '0);
        nop(1'b0);

        for (int k = 0; k < 12; k++) begin
            step(tbl[k].re, tbl[k].ra, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].wm,
                 1'b0, tbl[k].ev, tbl[k].eda, tbl[k].edb, 1'b0);
        end

        // Requested flush: the co-issued read still sees the old row.
        for (int i = 0; i < D; i++) wr(AW'(i), pat(i), '1);
        step(1'b1, 6'd2, 1'b0, '0, '0, '0, 1'b1, 1'b1, pat(2), pat(2), 1'b1);
        for (int i = 0; i < D; i++) begin
            step(1'b1, AW'(i), 1'b1, AW'(i + 63), ones, '1, 1'(i & 1),
                 1'b0, '0, '0, i < D - 1);
        end
        for (int i = 0; i < D; i++) rd(AW'(i), '0, '0);
        nop(1'b0);

        // Reset in the middle of a flush restarts it from row 0.
        wr(6'd7, pat(7), '1);
        step(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
        repeat (19) nop(1'b1);
        rst_n = 1'b0;
        nop(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) nop(i < D - 1);
        step(1'b1, 6'd3, 1'b1, 6'd3, pat(3), '1, 1'b0, 1'b1, pat(3), '0, 1'b0);
        rd(6'd3, pat(3), pat(3));
        rd(6'd7, '0, '0);
        rd(6'd40, '0, '0);
        rd(6'd63, '0, '0);

        // 48-row instance: out-of-range accesses.
        for (int i = 0; i < 48; i++) begin
            stepc(1'b0, '0, 1'b1, AW'(i), cpat(i), 4'hF, 1'b0, '0);
        end
        stepc(1'b0, '0, 1'b1, 6'd50, '1, 4'hF, 1'b0, '0);
        stepc(1'b1, 6'd50, 1'b0, '0, '0, '0, 1'b1, '0);
        stepc(1'b1, 6'd50, 1'b1, 6'd50, '1, 4'hF, 1'b1, '0);
        for (int i = 0; i < 48; i++) begin
            stepc(1'b1, AW'(i), 1'b0, '0, '0, '0, 1'b1, cpat(i));
        end
        stepc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
        stepc(1'b1, 6'd47, 1'b1, 6'd47, '0, 4'b0011, 1'b1, cpat(47) & 32'hFFFF_0000);
        stepc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
